// File: rtl/reg_file_rename_if.sv
// ----------------------------------------------------------------------------
// reg_file_rename_if
// Bundle between the ROB commit port / dispatcher and the architectural
// register file with per-register rename tags.
//   master : the ROB/dispatcher side (drives control, commit, rename, reads)
//   slave  : the register file (returns operand value/alias and pending count)
// Signals:
//   rdy                     global ready; low freezes all state
//   rollback                mispredict flush, clears every tag
//   commit_valid/rd/alias/data  retiring result from the ROB
//   rename_valid/rd/alias   destination alias recorded at dispatch
//   rs1/rs2                 source register indices
//   q1/v1, q2/v2            operand alias (0 = value valid) and value
//   pending_count           registered count of registers with a live tag
// ----------------------------------------------------------------------------
interface reg_file_rename_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4
);
  logic              rdy;
  logic              rollback;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_rd;
  logic [ROB_W-1:0]  commit_alias;
  logic [DATA_W-1:0] commit_data;
  logic              rename_valid;
  logic [REG_W-1:0]  rename_rd;
  logic [ROB_W-1:0]  rename_alias;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [ROB_W-1:0]  q1;
  logic [DATA_W-1:0] v1;
  logic [ROB_W-1:0]  q2;
  logic [DATA_W-1:0] v2;
  logic [5:0]        pending_count;

  modport master (
    output rdy, rollback,
    output commit_valid, commit_rd, commit_alias, commit_data,
    output rename_valid, rename_rd, rename_alias,
    output rs1, rs2,
    input  q1, v1, q2, v2, pending_count
  );

  modport slave (
    input  rdy, rollback,
    input  commit_valid, commit_rd, commit_alias, commit_data,
    input  rename_valid, rename_rd, rename_alias,
    input  rs1, rs2,
    output q1, v1, q2, v2, pending_count
  );
endinterface

// File: rtl/reg_file_rename.sv
// ----------------------------------------------------------------------------
// reg_file_rename
// Architectural register file x0..x31 with one rename tag per register.
// Commits from the ROB write values and clear the tag when the retiring ROB
// entry is still the register's newest producer; the dispatcher records new
// aliases on rename. Two combinational read ports return either a value or
// the pending ROB alias, with a same-cycle bypass from the commit port.
// Ports:
//   clk     clock
//   rst     synchronous, active-high reset (wins over rdy)
//   rf_bus  reg_file_rename_if.slave (see interface for signal list)
// ----------------------------------------------------------------------------
module reg_file_rename #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_file_rename_if.slave        rf_bus
);
  localparam int NREG = 1 << REG_W;

  typedef struct packed {
    logic [ROB_W-1:0]  q;
    logic [DATA_W-1:0] v;
  } operand_t;

  logic [DATA_W-1:0] r_value [NREG];
  logic [ROB_W-1:0]  r_tag   [NREG];
  logic [5:0]        r_pending_count;

  logic [ROB_W-1:0]  w_tag_next [NREG];
  logic [5:0]        w_count_next;
  operand_t          w_op1;
  operand_t          w_op2;

  // Read one source against current state. Renames in the same cycle are
  // invisible here; only a matching commit is forwarded.
  function automatic operand_t read_operand(input logic [REG_W-1:0] rs);
    operand_t op;
    op = '0;
    if (rs != '0) begin
      if (r_tag[rs] != '0 && rf_bus.commit_valid &&
          rf_bus.commit_rd == rs && rf_bus.commit_alias == r_tag[rs]) begin
        op.q = '0;
        op.v = rf_bus.commit_data;
      end else begin
        op.q = r_tag[rs];
        op.v = r_value[rs];
      end
    end
    return op;
  endfunction

  always_comb begin
    w_op1 = read_operand(rf_bus.rs1);
    w_op2 = read_operand(rf_bus.rs2);
  end

  assign rf_bus.q1            = w_op1.q;
  assign rf_bus.v1            = w_op1.v;
  assign rf_bus.q2            = w_op2.q;
  assign rf_bus.v2            = w_op2.v;
  assign rf_bus.pending_count = r_pending_count;

  // Next-state tags. Clear is applied before rename so a rename onto the
  // register being retired in the same cycle keeps the new alias.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would infer a latch.
    for (int i = 0; i < NREG; i++) w_tag_next[i] = r_tag[i];
    if (rf_bus.rollback) begin
      for (int i = 0; i < NREG; i++) w_tag_next[i] = '0;
    end else begin
      if (rf_bus.commit_valid && rf_bus.commit_rd != '0 &&
          r_tag[rf_bus.commit_rd] == rf_bus.commit_alias)
        w_tag_next[rf_bus.commit_rd] = '0;
      if (rf_bus.rename_valid && rf_bus.rename_rd != '0)
        w_tag_next[rf_bus.rename_rd] = rf_bus.rename_alias;
    end
    // x0 never carries a tag.
    w_tag_next[0] = '0;
  end

  // Count live tags in the state about to be loaded, so the registered
  // count lines up with the tag array after the edge.
  always_comb begin
    w_count_next = '0;
    for (int i = 1; i < NREG; i++)
      if (w_tag_next[i] != '0) w_count_next = w_count_next + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the value array is reset explicitly because software may read
      // any register before writing it and must see zero; this costs a reset
      // on every flop rather than allowing a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_pending_count <= '0;
    end else if (rf_bus.rdy) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NREG; i++) r_tag[i] <= w_tag_next[i];
      r_pending_count <= w_count_next;
      // Commit writes the value even when a younger producer owns the tag,
      // and even during rollback.
      if (rf_bus.commit_valid && rf_bus.commit_rd != '0)
        r_value[rf_bus.commit_rd] <= rf_bus.commit_data;
    end
  end
endmodule

// File: tb/tb_reg_file_rename.sv
// ----------------------------------------------------------------------------
// tb_reg_file_rename
// Directed test of reg_file_rename: reset, rename/commit with bypass, stale
// commit, clear-vs-rename collision, rollback, x0 handling and rdy stall.
// ----------------------------------------------------------------------------
module tb_reg_file_rename;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_rename_if #(.DATA_W(32), .REG_W(5), .ROB_W(4)) rf_bus ();

  reg_file_rename #(.DATA_W(32), .REG_W(5), .ROB_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (rf_bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // An alias of 0 would mark the destination as having no pending producer.
  always @(posedge clk) begin
    if (!rst && rf_bus.rdy && rf_bus.rename_valid)
      assert (rf_bus.rename_alias != 4'd0)
        else $error("illegal rename_alias 0 on rd %0d", rf_bus.rename_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    rf_bus.rollback     = 1'b0;
    rf_bus.commit_valid = 1'b0;
    rf_bus.commit_rd    = '0;
    rf_bus.commit_alias = '0;
    rf_bus.commit_data  = '0;
    rf_bus.rename_valid = 1'b0;
    rf_bus.rename_rd    = '0;
    rf_bus.rename_alias = '0;
  endtask

  task automatic do_rename(input logic [4:0] rd, input logic [3:0] alias_id);
    rf_bus.rename_valid = 1'b1;
    rf_bus.rename_rd    = rd;
    rf_bus.rename_alias = alias_id;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] alias_id,
                           input logic [31:0] data);
    rf_bus.commit_valid = 1'b1;
    rf_bus.commit_rd    = rd;
    rf_bus.commit_alias = alias_id;
    rf_bus.commit_data  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rf_bus.rdy = 1'b1;
    rf_bus.rs1 = 5'd5;
    rf_bus.rs2 = 5'd0;
    clear_strobes();
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_q1", 32'(rf_bus.q1), 32'd0);
    check("rst_v1", rf_bus.v1, 32'd0);
    check("rst_q2", 32'(rf_bus.q2), 32'd0);
    check("rst_v2", rf_bus.v2, 32'd0);
    check("rst_pend", 32'(rf_bus.pending_count), 32'd0);

    // Rename x5 -> 3, then commit with same-cycle bypass
    do_rename(5'd5, 4'd3);
    step();
    clear_strobes();
    #1;
    check("ren_q1", 32'(rf_bus.q1), 32'd3);
    check("ren_pend", 32'(rf_bus.pending_count), 32'd1);
    do_commit(5'd5, 4'd3, 32'hDEADBEEF);
    #1;
    check("byp_q1", 32'(rf_bus.q1), 32'd0);
    check("byp_v1", rf_bus.v1, 32'hDEADBEEF);
    step();
    clear_strobes();
    #1;
    check("cmt_q1", 32'(rf_bus.q1), 32'd0);
    check("cmt_v1", rf_bus.v1, 32'hDEADBEEF);
    check("cmt_pend", 32'(rf_bus.pending_count), 32'd0);

    // Stale commit: x7 renamed twice, older producer retires first
    rf_bus.rs1 = 5'd7;
    do_rename(5'd7, 4'd2);
    step();
    do_rename(5'd7, 4'd9);
    step();
    clear_strobes();
    do_commit(5'd7, 4'd2, 32'h11);
    #1;
    check("stale_nobyp_q1", 32'(rf_bus.q1), 32'd9);
    step();
    clear_strobes();
    #1;
    check("stale_q1", 32'(rf_bus.q1), 32'd9);
    check("stale_v1", rf_bus.v1, 32'h11);
    check("stale_pend", 32'(rf_bus.pending_count), 32'd1);
    do_commit(5'd7, 4'd9, 32'h22);
    step();
    clear_strobes();
    #1;
    check("young_q1", 32'(rf_bus.q1), 32'd0);
    check("young_v1", rf_bus.v1, 32'h22);
    check("young_pend", 32'(rf_bus.pending_count), 32'd0);

    // Clear and rename of x4 in the same cycle: rename wins
    rf_bus.rs2 = 5'd4;
    do_rename(5'd4, 4'd6);
    step();
    clear_strobes();
    do_commit(5'd4, 4'd6, 32'h44);
    do_rename(5'd4, 4'd8);
    step();
    clear_strobes();
    #1;
    check("coll_q2", 32'(rf_bus.q2), 32'd8);
    check("coll_v2", rf_bus.v2, 32'h44);
    check("coll_pend", 32'(rf_bus.pending_count), 32'd1);
    do_commit(5'd4, 4'd8, 32'h44);
    step();
    clear_strobes();

    // Rollback with a concurrent rename and commit
    do_rename(5'd1, 4'd1);
    step();
    do_rename(5'd2, 4'd2);
    step();
    do_rename(5'd3, 4'd3);
    step();
    clear_strobes();
    #1;
    check("rb_pre_pend", 32'(rf_bus.pending_count), 32'd3);
    rf_bus.rollback = 1'b1;
    do_rename(5'd9, 4'd4);
    do_commit(5'd2, 4'd2, 32'h55);
    step();
    clear_strobes();
    rf_bus.rs1 = 5'd2;
    rf_bus.rs2 = 5'd9;
    #1;
    check("rb_q_x2", 32'(rf_bus.q1), 32'd0);
    check("rb_v_x2", rf_bus.v1, 32'h55);
    check("rb_q_x9", 32'(rf_bus.q2), 32'd0);
    check("rb_pend", 32'(rf_bus.pending_count), 32'd0);
    rf_bus.rs1 = 5'd1;
    rf_bus.rs2 = 5'd3;
    #1;
    check("rb_q_x1", 32'(rf_bus.q1), 32'd0);
    check("rb_q_x3", 32'(rf_bus.q2), 32'd0);

    // x0: rename and commit are both discarded
    rf_bus.rs1 = 5'd0;
    do_rename(5'd0, 4'd5);
    do_commit(5'd0, 4'd5, 32'hFF);
    #1;
    check("x0_byp_v1", rf_bus.v1, 32'd0);
    step();
    clear_strobes();
    #1;
    check("x0_q1", 32'(rf_bus.q1), 32'd0);
    check("x0_v1", rf_bus.v1, 32'd0);
    check("x0_pend", 32'(rf_bus.pending_count), 32'd0);

    // rdy low: rename ignored
    rf_bus.rs1 = 5'd6;
    rf_bus.rdy = 1'b0;
    do_rename(5'd6, 4'd7);
    step();
    clear_strobes();
    #1;
    check("stall_q1", 32'(rf_bus.q1), 32'd0);
    check("stall_pend", 32'(rf_bus.pending_count), 32'd0);
    rf_bus.rdy = 1'b1;
    step();
    #1;
    check("unstall_q1", 32'(rf_bus.q1), 32'd0);

    // rdy low: bypass still visible, but commit does not take effect
    rf_bus.rs1 = 5'd10;
    do_rename(5'd10, 4'd5);
    step();
    clear_strobes();
    rf_bus.rdy = 1'b0;
    do_commit(5'd10, 4'd5, 32'hABCD);
    #1;
    check("stall_byp_q1", 32'(rf_bus.q1), 32'd0);
    check("stall_byp_v1", rf_bus.v1, 32'hABCD);
    step();
    clear_strobes();
    #1;
    check("stall_hold_q1", 32'(rf_bus.q1), 32'd5);
    check("stall_hold_v1", rf_bus.v1, 32'd0);
    check("stall_hold_pend", 32'(rf_bus.pending_count), 32'd1);
    rf_bus.rdy = 1'b1;
    do_commit(5'd10, 4'd5, 32'hABCD);
    step();
    clear_strobes();
    #1;
    check("resume_v1", rf_bus.v1, 32'hABCD);
    check("resume_pend", 32'(rf_bus.pending_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
